// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: control-bundle layout, zero-register index,
// and the producer/consumer register match used by forwarding and hazard logic.
package cpu_pkg;

  // Architectural zero register; never written, never forwarded.
  localparam logic [4:0] XZR = 5'd31;

  // Bit positions inside the decoded control bundle.
  localparam int unsigned MemReadBit  = 0;
  localparam int unsigned RegWriteBit = 1;

  localparam int unsigned CtrlDefaultW = 10;

  // Default-width control bundle; wider/narrower builds index by the bit constants.
  typedef struct packed {
    logic [CtrlDefaultW-3:0] other;
    logic                    reg_write;
    logic                    mem_read;
  } ctrl_t;

  // True when an enabled producer writing rd supplies source register rs.
  function automatic logic reg_match(input logic       en,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
    return en && (rd != XZR) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand select for one source register: zero register, then EX/MEM bypass,
// then MEM/WB bypass, then register-file data.
// Config macro: ID_EX_FWD_EN (defined = EX/MEM bypass present).
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int unsigned BITS = 64
) (
  input  logic [4:0]      rs,
  input  logic [BITS-1:0] rf_data,
`ifdef ID_EX_FWD_EN
  input  logic            exmem_we,
  input  logic [4:0]      exmem_rd,
  input  logic [BITS-1:0] exmem_data,
`endif
  input  logic            memwb_we,
  input  logic [4:0]      memwb_rd,
  input  logic [BITS-1:0] memwb_data,
  output logic [BITS-1:0] operand
);

  // Priority chain; the youngest producer wins.
  always_comb begin
    operand = rf_data;
    if (rs == XZR) begin
      operand = '0;
`ifdef ID_EX_FWD_EN
    end else if (reg_match(exmem_we, exmem_rd, rs)) begin
      operand = exmem_data;
`endif
    end else if (reg_match(memwb_we, memwb_rd, rs)) begin
      operand = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection,
// flush-to-bubble and a saturating bubble counter.
// Config macro: ID_EX_FWD_EN. Undefined: no EX/MEM bypass, so any RAW against
// an EX-stage or EX/MEM-stage register writer stalls instead.
module id_ex_reg
  import cpu_pkg::*;
#(
  parameter int unsigned BITS   = 64,
  parameter int unsigned CTRL_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [4:0]        id_Rn,
  input  logic [4:0]        id_Rm,
  input  logic [4:0]        id_Rd,
  input  logic [BITS-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [BITS-1:0]   ReadData1,
  input  logic [BITS-1:0]   ReadData2,
  input  logic              exmem_RegWrite,
  input  logic [4:0]        exmem_Rd,
  input  logic [BITS-1:0]   exmem_result,
  input  logic              memwb_RegWrite,
  input  logic [4:0]        memwb_Rd,
  input  logic [BITS-1:0]   memwb_WriteData,
  input  logic              flush,
  output logic              ex_valid,
  output logic [BITS-1:0]   ex_A,
  output logic [BITS-1:0]   ex_B,
  output logic [BITS-1:0]   ex_imm,
  output logic [4:0]        ex_Rn,
  output logic [4:0]        ex_Rm,
  output logic [4:0]        ex_Rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall,
  output logic [15:0]       bubble_cnt
);

  logic [BITS-1:0] a_sel;
  logic [BITS-1:0] b_sel;
  logic            reads_ex;
  logic            hazard;
  logic            bubble;

`ifndef ID_EX_FWD_EN
  // EX/MEM result has no consumer when its bypass is compiled out.
  logic unused_exmem_result;
  assign unused_exmem_result = ^exmem_result;
`endif

  fwd_sel #(
    .BITS(BITS)
  ) u_fwd_a (
    .rs        (id_Rn),
    .rf_data   (ReadData1),
`ifdef ID_EX_FWD_EN
    .exmem_we  (exmem_RegWrite),
    .exmem_rd  (exmem_Rd),
    .exmem_data(exmem_result),
`endif
    .memwb_we  (memwb_RegWrite),
    .memwb_rd  (memwb_Rd),
    .memwb_data(memwb_WriteData),
    .operand   (a_sel)
  );

  fwd_sel #(
    .BITS(BITS)
  ) u_fwd_b (
    .rs        (id_Rm),
    .rf_data   (ReadData2),
`ifdef ID_EX_FWD_EN
    .exmem_we  (exmem_RegWrite),
    .exmem_rd  (exmem_Rd),
    .exmem_data(exmem_result),
`endif
    .memwb_we  (memwb_RegWrite),
    .memwb_rd  (memwb_Rd),
    .memwb_data(memwb_WriteData),
    .operand   (b_sel)
  );

  // Hazard detection; flush overrides stall, and reset forces stall low.
  always_comb begin
    reads_ex = (ex_Rd != XZR) && ((ex_Rd == id_Rn) || (ex_Rd == id_Rm));
    hazard   = id_valid && ex_valid && ex_ctrl[MemReadBit] && reads_ex;
`ifndef ID_EX_FWD_EN
    hazard   = hazard
             || (id_valid && ex_valid && ex_ctrl[RegWriteBit] && reads_ex)
             || (id_valid && (reg_match(exmem_RegWrite, exmem_Rd, id_Rn)
                           || reg_match(exmem_RegWrite, exmem_Rd, id_Rm)));
`endif
    stall    = hazard && !flush && reset_n;
    bubble   = stall || flush;
  end

  // EX-stage bundle: capture decode fields, or insert a bubble holding data fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_A     <= '0;
      ex_B     <= '0;
      ex_imm   <= '0;
      ex_Rn    <= XZR;
      ex_Rm    <= XZR;
      ex_Rd    <= XZR;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid <= id_valid;
      // Control is masked so an invalid slot never carries live control bits.
      ex_ctrl  <= id_valid ? id_ctrl : '0;
      ex_A     <= a_sel;
      ex_B     <= b_sel;
      ex_imm   <= id_imm;
      ex_Rn    <= id_Rn;
      ex_Rm    <= id_Rm;
      ex_Rd    <= id_Rd;
    end
  end

  // Saturating count of inserted bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: behavioural model compared every cycle,
// directed cases with literal expectations, random traffic, counter saturation.
module tb_id_ex_reg;

  localparam int unsigned BITS   = 64;
  localparam int unsigned CTRL_W = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              id_valid;
  logic [4:0]        id_Rn, id_Rm, id_Rd;
  logic [BITS-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [BITS-1:0]   ReadData1, ReadData2;
  logic              exmem_RegWrite;
  logic [4:0]        exmem_Rd;
  logic [BITS-1:0]   exmem_result;
  logic              memwb_RegWrite;
  logic [4:0]        memwb_Rd;
  logic [BITS-1:0]   memwb_WriteData;
  logic              flush;
  logic              ex_valid;
  logic [BITS-1:0]   ex_A, ex_B, ex_imm;
  logic [4:0]        ex_Rn, ex_Rm, ex_Rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              stall;
  logic [15:0]       bubble_cnt;

  always #5 clk = ~clk;

  id_ex_reg #(
    .BITS  (BITS),
    .CTRL_W(CTRL_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_valid       (id_valid),
    .id_Rn          (id_Rn),
    .id_Rm          (id_Rm),
    .id_Rd          (id_Rd),
    .id_imm         (id_imm),
    .id_ctrl        (id_ctrl),
    .ReadData1      (ReadData1),
    .ReadData2      (ReadData2),
    .exmem_RegWrite (exmem_RegWrite),
    .exmem_Rd       (exmem_Rd),
    .exmem_result   (exmem_result),
    .memwb_RegWrite (memwb_RegWrite),
    .memwb_Rd       (memwb_Rd),
    .memwb_WriteData(memwb_WriteData),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_A           (ex_A),
    .ex_B           (ex_B),
    .ex_imm         (ex_imm),
    .ex_Rn          (ex_Rn),
    .ex_Rm          (ex_Rm),
    .ex_Rd          (ex_Rd),
    .ex_ctrl        (ex_ctrl),
    .stall          (stall),
    .bubble_cnt     (bubble_cnt)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int bc0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [63:0]       m_A, m_B, m_imm;
  logic [4:0]        m_Rn, m_Rm, m_Rd;
  int                m_bc;

  function automatic logic [63:0] m_pick(input logic [4:0] rs, input logic [63:0] rf);
    if (rs == 5'd31) return 64'd0;
`ifdef ID_EX_FWD_EN
    if (exmem_RegWrite && exmem_Rd != 5'd31 && exmem_Rd == rs) return exmem_result;
`endif
    if (memwb_RegWrite && memwb_Rd != 5'd31 && memwb_Rd == rs) return memwb_WriteData;
    return rf;
  endfunction

  function automatic bit m_reads(input logic [4:0] r);
    return (r != 5'd31) && (r == id_Rn || r == id_Rm);
  endfunction

  function automatic bit m_stall();
    bit h;
    if (!reset_n || flush || !id_valid) return 1'b0;
    h = m_valid && m_ctrl[0] && m_reads(m_Rd);
`ifndef ID_EX_FWD_EN
    h = h || (m_valid && m_ctrl[1] && m_reads(m_Rd)) || (exmem_RegWrite && m_reads(exmem_Rd));
`endif
    return h;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0; m_ctrl <= '0; m_A <= '0; m_B <= '0; m_imm <= '0;
      m_Rn <= 5'd31; m_Rm <= 5'd31; m_Rd <= 5'd31; m_bc <= 0;
    end else if (flush || m_stall()) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_bc    <= (m_bc < 65535) ? m_bc + 1 : 65535;
    end else begin
      m_valid <= id_valid;
      m_ctrl  <= id_valid ? id_ctrl : '0;
      m_A     <= m_pick(id_Rn, ReadData1);
      m_B     <= m_pick(id_Rm, ReadData2);
      m_imm   <= id_imm;
      m_Rn    <= id_Rn;
      m_Rm    <= id_Rm;
      m_Rd    <= id_Rd;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ex_valid", 64'(ex_valid), 64'(m_valid));
      check("cyc_ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
      check("cyc_ex_A", ex_A, m_A);
      check("cyc_ex_B", ex_B, m_B);
      check("cyc_ex_imm", ex_imm, m_imm);
      check("cyc_ex_regs", 64'({ex_Rn, ex_Rm, ex_Rd}), 64'({m_Rn, m_Rm, m_Rd}));
      check("cyc_bubble_cnt", 64'(bubble_cnt), 64'(m_bc));
      check("cyc_stall", 64'(stall), 64'(m_stall()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid = 1'b0; id_Rn = 5'd31; id_Rm = 5'd31; id_Rd = 5'd31;
    id_imm = '0; id_ctrl = '0; ReadData1 = '0; ReadData2 = '0;
    exmem_RegWrite = 1'b0; exmem_Rd = 5'd31; exmem_result = '0;
    memwb_RegWrite = 1'b0; memwb_Rd = 5'd31; memwb_WriteData = '0;
    flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rreg();
    int unsigned v;
    v = $urandom_range(0, 5);
    return (v == 5) ? 5'd31 : 5'(v);
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_ex_Rd", 64'(ex_Rd), 64'd31);
    check("rst_ex_A", ex_A, 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;
    step();

    // EX/MEM producer feeding Rn
    idle();
    id_valid = 1'b1; id_Rn = 5'd3; id_Rd = 5'd7; id_ctrl = 10'h002; id_imm = 64'h10;
    exmem_RegWrite = 1'b1; exmem_Rd = 5'd3; exmem_result = 64'hAA;
`ifdef ID_EX_FWD_EN
    step();
    check("fwd_exmem_A", ex_A, 64'hAA);
    check("fwd_exmem_valid", 64'(ex_valid), 64'd1);
`else
    #1 check("nofwd_stall", 64'(stall), 64'd1);
    step();
    check("nofwd_bubble", 64'(ex_valid), 64'd0);
    exmem_RegWrite = 1'b0;
    memwb_RegWrite = 1'b1; memwb_Rd = 5'd3; memwb_WriteData = 64'hAA;
    step();
    check("nofwd_wb_A", ex_A, 64'hAA);
`endif

    // Priority between producers, and zero register
    idle();
    id_valid = 1'b1; id_Rn = 5'd3; id_Rd = 5'd8; id_ctrl = 10'h002;
    memwb_RegWrite = 1'b1; memwb_Rd = 5'd3; memwb_WriteData = 64'hBB;
`ifdef ID_EX_FWD_EN
    exmem_RegWrite = 1'b1; exmem_Rd = 5'd3; exmem_result = 64'hAA;
    step();
    check("prio_A", ex_A, 64'hAA);
`else
    step();
    check("prio_A", ex_A, 64'hBB);
`endif
    idle();
    id_valid = 1'b1; id_Rn = 5'd31; ReadData1 = 64'h55; id_ctrl = 10'h002;
    exmem_RegWrite = 1'b1; exmem_result = 64'hAA;
    memwb_RegWrite = 1'b1; memwb_WriteData = 64'hBB;
    step();
    check("xzr_A", ex_A, 64'd0);

    // Load-use: LDUR X5 then consumer of X5 in Rm
    idle();
    id_valid = 1'b1; id_ctrl = 10'h003; id_Rd = 5'd5; id_Rn = 5'd1;
    step();
    idle();
    id_valid = 1'b1; id_Rn = 5'd2; id_Rm = 5'd5; id_Rd = 5'd6; id_ctrl = 10'h002;
    ReadData2 = 64'h123;
    bc0 = m_bc;
    #1 check("lu_stall", 64'(stall), 64'd1);
    step();
    check("lu_bubble", 64'(ex_valid), 64'd0);
    check("lu_bc", 64'(bubble_cnt), 64'(bc0 + 1));
    check("lu_stall_clear", 64'(stall), 64'd0);
    memwb_RegWrite = 1'b1; memwb_Rd = 5'd5; memwb_WriteData = 64'hBEEF;
    step();
    check("lu_valid", 64'(ex_valid), 64'd1);
    check("lu_B", ex_B, 64'hBEEF);
    check("lu_Rd", 64'(ex_Rd), 64'd6);

    // Flush together with a load-use hazard: single bubble, no stall
    idle();
    id_valid = 1'b1; id_ctrl = 10'h003; id_Rd = 5'd5;
    step();
    idle();
    id_valid = 1'b1; id_Rm = 5'd5; id_Rd = 5'd9; id_ctrl = 10'h002; flush = 1'b1;
    bc0 = m_bc;
    #1 check("fh_stall", 64'(stall), 64'd0);
    step();
    check("fh_bubble", 64'(ex_valid), 64'd0);
    check("fh_bc", 64'(bubble_cnt), 64'(bc0 + 1));
    flush = 1'b0;
    step();
    check("fh_next_valid", 64'(ex_valid), 64'd1);
    check("fh_bc_once", 64'(bubble_cnt), 64'(bc0 + 1));
    check("fh_next_Rd", 64'(ex_Rd), 64'd9);

    // Invalid slot must not carry control bits
    idle();
    id_ctrl = '1;
    step();
    check("inv_ctrl", 64'(ex_ctrl), 64'd0);

    // Reset asserted mid-stall discards the stalled instruction
    idle();
    id_valid = 1'b1; id_ctrl = 10'h003; id_Rd = 5'd5;
    step();
    idle();
    id_valid = 1'b1; id_Rn = 5'd5; id_Rd = 5'd12; id_ctrl = 10'h002;
    #1 check("rs_stall", 64'(stall), 64'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rs_ex_valid", 64'(ex_valid), 64'd0);
    check("rs_bc", 64'(bubble_cnt), 64'd0);
    check("rs_ex_Rd", 64'(ex_Rd), 64'd31);
    check("rs_stall_low", 64'(stall), 64'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    step();
    check("rs_capture_valid", 64'(ex_valid), 64'd1);
    check("rs_capture_Rd", 64'(ex_Rd), 64'd12);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      id_valid        = ($urandom_range(0, 3) != 0);
      id_Rn           = rreg();
      id_Rm           = rreg();
      id_Rd           = rreg();
      id_imm          = {$urandom, $urandom};
      id_ctrl         = CTRL_W'($urandom);
      ReadData1       = {$urandom, $urandom};
      ReadData2       = {$urandom, $urandom};
      exmem_RegWrite  = 1'($urandom_range(0, 1));
      exmem_Rd        = rreg();
      exmem_result    = {$urandom, $urandom};
      memwb_RegWrite  = 1'($urandom_range(0, 1));
      memwb_Rd        = rreg();
      memwb_WriteData = {$urandom, $urandom};
      flush           = ($urandom_range(0, 9) == 0);
      step();
    end

    // Saturation: 65537 forced bubbles from a fresh reset
    idle();
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    flush = 1'b1;
    repeat (65534) @(posedge clk);
    #1 check("sat_fffe", 64'(bubble_cnt), 64'hFFFE);
    step();
    check("sat_ffff", 64'(bubble_cnt), 64'hFFFF);
    step();
    step();
    check("sat_hold", 64'(bubble_cnt), 64'hFFFF);
    flush = 1'b0;
    step();
    check("sat_hold_idle", 64'(bubble_cnt), 64'hFFFF);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter BITS, default 64, datapath width.
REQ-002 SHALL have parameter CTRL_W, default 10, decoded control bundle width; bit 0 = MemRead, bit 1 = RegWrite.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports id_valid in 1, id_Rn/id_Rm/id_Rd in 5, id_imm in BITS, id_ctrl in CTRL_W: decode-stage instruction fields.
REQ-006 SHALL have ports ReadData1/ReadData2  in  BITS  register-file outputs for id_Rn/id_Rm.
REQ-007 SHALL have ports exmem_RegWrite in 1, exmem_Rd in 5, exmem_result in BITS: MEM-stage producer.
REQ-008 SHALL have ports memwb_RegWrite in 1, memwb_Rd in 5, memwb_WriteData in BITS: WB-stage producer, same values driving the register-file write port.
REQ-009 SHALL have port flush  in  1  squash the decode-stage instruction (taken branch).
REQ-010 SHALL have outputs ex_valid 1, ex_A/ex_B BITS, ex_imm BITS, ex_Rn/ex_Rm/ex_Rd 5, ex_ctrl CTRL_W: registered EX-stage bundle.
REQ-011 SHALL have output stall  1  combinational; holds PC and IF/ID when high.
REQ-012 SHALL have output bubble_cnt  16  registered count of bubbles inserted.

Function
REQ-013 Operand select per source, priority: index 31 -> zero; EX/MEM match with exmem_RegWrite -> exmem_result; MEM/WB match with memwb_RegWrite -> memwb_WriteData; else ReadData.
REQ-014 A producer with Rd = 31 SHALL never be forwarded.
REQ-015 Load-use hazard = id_valid & ex_valid & ex_ctrl[0] & ex_Rd != 31 & (ex_Rd == id_Rn | ex_Rd == id_Rm).
REQ-016 stall SHALL equal hazard & ~flush.
REQ-017 Each edge with ~stall & ~flush: capture all id_* fields and selected operands; ex_valid <= id_valid; latency one cycle.
REQ-018 Each edge with stall or flush: insert bubble -- ex_valid <= 0, ex_ctrl <= 0; data fields don't-care, held.
REQ-019 flush and hazard together: flush wins, stall = 0, one bubble.
REQ-020 bubble_cnt SHALL increment on every bubble edge (REQ-018) and saturate at 16'hFFFF.
REQ-021 ex_ctrl SHALL be all-zero whenever ex_valid = 0.

Reset
REQ-022 On reset_n low, immediately: ex_valid = 0, ex_ctrl = 0, ex_A = ex_B = ex_imm = 0, ex_Rn = ex_Rm = ex_Rd = 31, bubble_cnt = 0.
REQ-023 stall SHALL be 0 during reset, since ex_valid = 0.
REQ-024 Reset asserted mid-stall SHALL discard the stalled instruction; first post-reset edge captures normally.

Configuration
REQ-025 Macro ID_EX_FWD_EN defined: EX/MEM forwarding per REQ-013.
REQ-026 Macro ID_EX_FWD_EN undefined: EX/MEM forwarding removed; hazard additionally asserts for any RAW against a valid EX-stage RegWrite producer or exmem_RegWrite producer (Rd != 31); MEM/WB bypass is always present.

Structure
REQ-027 Package cpu_pkg SHALL hold the control-bundle typedef with MemRead/RegWrite bit positions and constant XZR = 5'd31.
REQ-028 A sub-module fwd_sel SHALL implement REQ-013 for one operand, instantiated twice.

Verification
REQ-029 Reset: reset_n = 0 mid-cycle -> ex_valid = 0, bubble_cnt = 0, ex_Rd = 31 without a clock edge.
REQ-030 EX/MEM forward: exmem_RegWrite = 1, exmem_Rd = 3, exmem_result = 64'hAA, id_Rn = 3, ReadData1 = 0 -> next cycle ex_A = 64'hAA.
REQ-031 Priority: EX/MEM and MEM/WB both Rd = 3 (0xAA, 0xBB) -> ex_A = 0xAA; both Rd = 31, id_Rn = 31 -> ex_A = 0.
REQ-032 Load-use: LDUR X5 in EX, id_Rm = 5 -> stall = 1 one cycle, ex_valid = 0, bubble_cnt = 1; next cycle captures with ex_B = memwb value.
REQ-033 Flush + hazard simultaneous -> stall = 0, ex_valid = 0, bubble_cnt increments once.
REQ-034 Saturation: 65 537 forced bubbles -> bubble_cnt = 16'hFFFF, held.
